// File: rtl/imem_arb_pkg.sv
// rtl/imem_arb_pkg.sv - shared owner encoding and default widths for the imem port arbiter
package imem_arb_pkg;

  localparam int ADDR_W_DEF = 30;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_e;

endpackage

// File: rtl/imem_starve_ctr.sv
// rtl/imem_starve_ctr.sv - counts consecutive denied DM cycles, flags when DM must be force-granted
module imem_starve_ctr
  import imem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic dm_req,
  input  logic dm_gnt,
  output logic at_max
);

  localparam logic [3:0] MAX = 4'(STARVE_MAX);

  logic [3:0] cnt;
  logic       denied;

  assign denied = dm_req && !dm_gnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!denied) begin
      cnt <= '0;
    end else if (cnt != MAX) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign at_max = (cnt == MAX);

endmodule

// File: rtl/imem_port_arbiter.sv
// rtl/imem_port_arbiter.sv - shares the single-port instruction ROM between IF and the DM read port
module imem_port_arbiter
  import imem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic [ADDR_W-1:0] dm_addr,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_rdata,
  output logic [CNT_W-1:0]  conflict_cnt
);

  logic              at_max;
  owner_e            owner;
  logic [ADDR_W-1:0] last_addr;

  imem_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk   (clk),
    .rst_n (rst_n),
    .dm_req(dm_req),
    .dm_gnt(dm_gnt),
    .at_max(at_max)
  );

  // Idle cycles keep the last address on the ROM so its address pins do not toggle.
  always_comb begin
    if_gnt   = 1'b0;
    dm_gnt   = 1'b0;
    rom_addr = last_addr;
    if (!rst_n) begin
      rom_addr = '0;
    end else begin
      if (if_req && !(dm_req && at_max)) begin
        if_gnt = 1'b1;
      end else if (dm_req) begin
        dm_gnt = 1'b1;
      end
      if (if_gnt) begin
        rom_addr = if_addr;
      end else if (dm_gnt) begin
        rom_addr = dm_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner        <= OWN_NONE;
      last_addr    <= '0;
      conflict_cnt <= '0;
    end else begin
      if (if_gnt) begin
        owner <= OWN_IF;
      end else if (dm_gnt) begin
        owner <= OWN_DM;
      end else begin
        owner <= OWN_NONE;
      end
      if (if_gnt || dm_gnt) begin
        last_addr <= rom_addr;
      end
      if (if_req && dm_req && (conflict_cnt != '1)) begin
        conflict_cnt <= conflict_cnt + 1'b1;
      end
    end
  end

  // Gating with rst_n drops a response whose grant was issued just before reset.
  assign if_rvalid = rst_n && (owner == OWN_IF);
  assign dm_rvalid = rst_n && (owner == OWN_DM);
  assign if_rdata  = if_rvalid ? rom_rdata : '0;
  assign dm_rdata  = dm_rvalid ? rom_rdata : '0;

endmodule
